// File: rtl/vga_frame_monitor.sv
// VGA sink: rebuilds pixel coordinates from sync edges, checks/locks to the
// frame timing and reports the per-frame bounding box of a target colour.
module vga_frame_monitor #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic [11:0] target_rgb,
  output logic        locked,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic        box_valid,
  output logic        box_found,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
  output logic [9:0]  box_y_max
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LOAD = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] X_PRE  = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LOAD = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] Y_PRE  = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]  state;
  logic        hs_prev, vs_prev;
  logic [11:0] rgb_q, target_q;
  logic        frame_bad;
  logic        acc_found;
  logic [9:0]  acc_x_min, acc_x_max, acc_y_min, acc_y_max;

  logic       hfall, vfall, x_wrap, hexp, vexp, h_bad, v_bad, match;
  logic [9:0] x_nxt, y_nxt;

  assign hfall  = pix_tick & hs_prev & ~hsync;
  assign vfall  = pix_tick & vs_prev & ~vsync;
  assign x_wrap = (pixel_x == X_LAST);
  assign hexp   = pix_tick & (pixel_x == X_PRE);
  // A vsync fall is expected exactly where y would naturally step onto its load value.
  assign vexp   = pix_tick & x_wrap & (pixel_y == Y_PRE);
  assign h_bad  = hfall ^ hexp;
  assign v_bad  = vfall ^ vexp;
  assign match  = video_on & (rgb_q == target_q);

  always_comb begin
    x_nxt = pixel_x + 10'd1;
    if (hfall)       x_nxt = X_LOAD;
    else if (x_wrap) x_nxt = 10'd0;
    y_nxt = pixel_y;
    if (vfall)                y_nxt = Y_LOAD;
    else if (x_wrap && !hfall) y_nxt = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SEARCH;
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      rgb_q      <= '0;
      target_q   <= '0;
      frame_bad  <= 1'b0;
      acc_found  <= 1'b0;
      acc_x_min  <= '0;
      acc_x_max  <= '0;
      acc_y_min  <= '0;
      acc_y_max  <= '0;
      locked     <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      video_on   <= 1'b0;
      timing_err <= 1'b0;
      err_count  <= '0;
      box_valid  <= 1'b0;
      box_found  <= 1'b0;
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
    end else begin
      timing_err <= 1'b0;
      box_valid  <= 1'b0;
      if (pix_tick) begin
        rgb_q    <= rgb;
        hs_prev  <= hsync;
        vs_prev  <= vsync;
        pixel_x  <= x_nxt;
        pixel_y  <= y_nxt;
        video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        if (vfall) target_q <= target_rgb;
        case (state)
          S_SEARCH: begin
            if (vfall) begin
              state     <= S_ALIGN;
              frame_bad <= 1'b0;
            end
          end
          S_ALIGN: begin
            if (vfall) begin
              if (!frame_bad && !h_bad && vexp) begin
                state     <= S_LOCKED;
                locked    <= 1'b1;
                acc_found <= 1'b0;
                acc_x_min <= '0;
                acc_x_max <= '0;
                acc_y_min <= '0;
                acc_y_max <= '0;
              end
              frame_bad <= 1'b0;
            end else if (h_bad) begin
              frame_bad <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (h_bad || v_bad) begin
              // Partial frame is dropped; the published box stays as it was.
              state      <= S_SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              acc_found  <= 1'b0;
            end else if (vfall) begin
              box_valid <= 1'b1;
              box_found <= acc_found;
              box_x_min <= acc_x_min;
              box_x_max <= acc_x_max;
              box_y_min <= acc_y_min;
              box_y_max <= acc_y_max;
              acc_found <= 1'b0;
              acc_x_min <= '0;
              acc_x_max <= '0;
              acc_y_min <= '0;
              acc_y_max <= '0;
            end else if (match) begin
              acc_found <= 1'b1;
              if (!acc_found) begin
                acc_x_min <= pixel_x;
                acc_x_max <= pixel_x;
                acc_y_min <= pixel_y;
                acc_y_max <= pixel_y;
              end else begin
                if (pixel_x < acc_x_min) acc_x_min <= pixel_x;
                if (pixel_x > acc_x_max) acc_x_max <= pixel_x;
                if (pixel_y < acc_y_min) acc_y_min <= pixel_y;
                if (pixel_y > acc_y_max) acc_y_max <= pixel_y;
              end
            end
          end
          default: begin
            state  <= S_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a scaled-down raster: a sync/pixel source with
// a running bounding-box model, a table of fixed scenes and random scenes.
module tb_vga_frame_monitor;
  localparam int HD = 24, HF = 2, HS = 4, HB = 2, HT = HD + HF + HS + HB;
  localparam int VD = 16, VF = 2, VS = 2, VB = 2, VT = VD + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * 4;

  logic        clk = 1'b0, rst = 1'b0, pix_tick = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [11:0] rgb = '0, target_rgb = '0;
  logic        locked, video_on, timing_err, box_valid, box_found;
  logic [9:0]  pixel_x, pixel_y, box_x_min, box_x_max, box_y_min, box_y_max;
  logic [7:0]  err_count;

  vga_frame_monitor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .target_rgb(target_rgb), .locked(locked), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .video_on(video_on), .timing_err(timing_err),
    .err_count(err_count), .box_valid(box_valid), .box_found(box_found),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min),
    .box_y_max(box_y_max)
  );

  always #5 clk = ~clk;

  typedef struct { int x0; int x1; int y0; int y1; logic [11:0] col; } rect_t;
  typedef struct { logic [11:0] tgt; logic found; int x0; int x1; int y0; int y1; } vec_t;

  rect_t scene[3];
  vec_t  tbl[4];
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [11:0] colour_at(int x, int y);
    for (int i = 0; i < 3; i++)
      if (x >= scene[i].x0 && x <= scene[i].x1 && y >= scene[i].y0 && y <= scene[i].y1)
        return scene[i].col;
    return 12'h000;
  endfunction

  // Source raster plus reference model: the box is built from the source's
  // own coordinates and published at every source vsync fall.
  int sx = 0, sy = 0, drv_x = 0, drv_y = 0, vf_cnt = 0;
  logic skip_req = 1'b0;
  logic [11:0] m_tgt = '0;
  logic m_found = 1'b0, e_found = 1'b0;
  int m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;
  int e_x0 = 0, e_x1 = 0, e_y0 = 0, e_y1 = 0;

  initial begin
    forever begin
      @(negedge clk);
      hsync = !(sx >= HD + HF && sx < HD + HF + HS);
      vsync = !(sy >= VD + VF && sy < VD + VF + VS);
      if (sx < HD && sy < VD) begin
        rgb = colour_at(sx, sy);
        if (rgb == m_tgt) begin
          if (!m_found) begin
            m_x0 = sx; m_x1 = sx; m_y0 = sy; m_y1 = sy;
          end else begin
            if (sx < m_x0) m_x0 = sx;
            if (sx > m_x1) m_x1 = sx;
            if (sy < m_y0) m_y0 = sy;
            if (sy > m_y1) m_y1 = sy;
          end
          m_found = 1'b1;
        end
      end else begin
        rgb = target_rgb;  // blanking carries the target colour; it must never be boxed
      end
      if (sx == 0 && sy == VD + VF) begin
        e_found = m_found; e_x0 = m_x0; e_x1 = m_x1; e_y0 = m_y0; e_y1 = m_y1;
        m_found = 1'b0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_tgt = target_rgb;
        vf_cnt++;
      end
      drv_x = sx; drv_y = sy;
      pix_tick = 1'b1;
      if (skip_req && sx == 5) begin
        sx = 7;
        skip_req = 1'b0;
      end else if (sx == HT - 1) begin
        sx = 0;
        sy = (sy == VT - 1) ? 0 : sy + 1;
      end else begin
        sx++;
      end
      @(negedge clk);
      pix_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  end

  int nbv = 0, nte = 0;
  logic chk_px = 1'b1, bv_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (pix_tick && locked && chk_px) begin
        chk("pixel_x", longint'(pixel_x), longint'(drv_x));
        chk("pixel_y", longint'(pixel_y), longint'(drv_y));
        chk("video_on", longint'(video_on), longint'(drv_x < HD && drv_y < VD));
      end
      if (box_valid) begin
        nbv++;
        chk("box_found", longint'(box_found), longint'(e_found));
        chk("box_x_min", longint'(box_x_min), longint'(e_x0));
        chk("box_x_max", longint'(box_x_max), longint'(e_x1));
        chk("box_y_min", longint'(box_y_min), longint'(e_y0));
        chk("box_y_max", longint'(box_y_max), longint'(e_y1));
      end
      if (bv_prev) chk("box_valid_1clk", longint'(box_valid), 0);
      if (timing_err) nte++;
    end
    bv_prev <= box_valid;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_locked"}, longint'(locked), 0);
    chk({tag, "_pixel_x"}, longint'(pixel_x), 0);
    chk({tag, "_pixel_y"}, longint'(pixel_y), 0);
    chk({tag, "_video_on"}, longint'(video_on), 0);
    chk({tag, "_timing_err"}, longint'(timing_err), 0);
    chk({tag, "_err_count"}, longint'(err_count), 0);
    chk({tag, "_box_valid"}, longint'(box_valid), 0);
    chk({tag, "_box_found"}, longint'(box_found), 0);
    chk({tag, "_box_x_min"}, longint'(box_x_min), 0);
    chk({tag, "_box_x_max"}, longint'(box_x_max), 0);
    chk({tag, "_box_y_min"}, longint'(box_y_min), 0);
    chk({tag, "_box_y_max"}, longint'(box_y_max), 0);
  endtask

  task automatic wait_vf(input int k, input string nm);
    int tgt = vf_cnt + k;
    int b = 0;
    while (vf_cnt < tgt && b < k * FRAME_CLK + 500) begin @(posedge clk); b++; end
    if (vf_cnt < tgt) chk(nm, vf_cnt, tgt);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_line(input int ln);
    int b = 0;
    while (sy == ln && b < 2 * FRAME_CLK) begin @(posedge clk); b++; end
    while (sy != ln && b < 2 * FRAME_CLK) begin @(posedge clk); b++; end
    if (sy != ln) chk("tmo_line", sy, ln);
  endtask

  task automatic wait_bv(input int nb0);
    int b = 0;
    while (nbv == nb0 && b < 2 * FRAME_CLK) begin @(posedge clk); b++; end
    if (nbv == nb0) chk("tmo_box_valid", nbv, nb0 + 1);
    #1;
  endtask

  function automatic void set_fixed_scene();
    scene[0] = '{x0: 1,  x1: 2,  y0: 0, y1: 15, col: 12'h070};  // wall
    scene[1] = '{x0: 20, x1: 21, y0: 5, y1: 9,  col: 12'h770};  // paddle
    scene[2] = '{x0: 12, x1: 14, y0: 7, y1: 9,  col: 12'hF0F};  // ball
  endfunction

  initial begin
    logic [11:0] pal[5];
    int nbv0, nte0, b, x0, y0;
    pal[0] = 12'h070; pal[1] = 12'h770; pal[2] = 12'hF0F; pal[3] = 12'h00F; pal[4] = 12'h123;
    tbl[0] = '{tgt: 12'h070, found: 1'b1, x0: 1,  x1: 2,  y0: 0, y1: 15};
    tbl[1] = '{tgt: 12'h770, found: 1'b1, x0: 20, x1: 21, y0: 5, y1: 9};
    tbl[2] = '{tgt: 12'hF0F, found: 1'b1, x0: 12, x1: 14, y0: 7, y1: 9};
    tbl[3] = '{tgt: 12'h123, found: 1'b0, x0: 0,  x1: 0,  y0: 0, y1: 0};
    set_fixed_scene();
    target_rgb = tbl[0].tgt;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;

    wait_vf(1, "tmo_vf1");
    chk("locked_after_vf1", longint'(locked), 0);
    wait_vf(1, "tmo_vf2");
    chk("locked_after_vf2", longint'(locked), 1);

    // Frames 0-3 use the fixed table scene, 4-8 random scenes.
    for (int f = 0; f < 9; f++) begin
      wait_line(VD);
      if (f + 1 < 4) begin
        target_rgb = tbl[f + 1].tgt;
      end else if (f + 1 < 9) begin
        for (int i = 0; i < 3; i++) begin
          x0 = int'($urandom_range(HD - 1, 0));
          y0 = int'($urandom_range(VD - 1, 0));
          scene[i].x0 = x0;
          scene[i].x1 = int'($urandom_range(HD - 1, x0));
          scene[i].y0 = y0;
          scene[i].y1 = int'($urandom_range(VD - 1, y0));
          scene[i].col = pal[$urandom_range(3, 0)];
        end
        target_rgb = pal[$urandom_range(4, 0)];
      end else begin
        set_fixed_scene();
        target_rgb = 12'h070;
      end
      nbv0 = nbv;
      wait_bv(nbv0);
      if (f < 4) begin
        chk("tbl_found", longint'(box_found), longint'(tbl[f].found));
        chk("tbl_x_min", longint'(box_x_min), longint'(tbl[f].x0));
        chk("tbl_x_max", longint'(box_x_max), longint'(tbl[f].x1));
        chk("tbl_y_min", longint'(box_y_min), longint'(tbl[f].y0));
        chk("tbl_y_max", longint'(box_y_max), longint'(tbl[f].y1));
      end
    end
    chk("no_timing_err_clean", nte, 0);

    // One line shortened by a pixel while locked.
    nbv0 = nbv;
    nte0 = nte;
    wait_line(3);
    chk_px = 1'b0;
    skip_req = 1'b1;
    wait_line(5);
    chk("err_locked", longint'(locked), 0);
    chk("err_pulses", nte - nte0, 1);
    chk("err_count", longint'(err_count), 1);
    wait_vf(1, "tmo_err_vf1");
    chk("err_locked_vf1", longint'(locked), 0);
    wait_vf(1, "tmo_err_vf2");
    chk("err_relock_vf2", longint'(locked), 1);
    chk("err_no_box_valid", nbv, nbv0);
    chk_px = 1'b1;
    wait_bv(nbv);
    chk("err_box_found", longint'(box_found), 1);

    // Reset in the middle of the visible area.
    wait_line(8);
    b = 0;
    while (sx != 10 && b < 4 * HT * 4) begin @(posedge clk); b++; end
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset("rst_mid");
    repeat (3) @(posedge clk);
    #1 check_reset("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    wait_vf(1, "tmo_rst_vf1");
    chk("rst_locked_vf1", longint'(locked), 0);
    wait_vf(1, "tmo_rst_vf2");
    chk("rst_relock_vf2", longint'(locked), 1);
    chk("rst_err_count", longint'(err_count), 0);
    wait_bv(nbv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $fatal(1, "watchdog");
  end
endmodule
